itch_exec_price_parser_p: RTL and testbench

ITCH_EXEC_PRICE_PARSER_P -- requirements
Module: itch_exec_price_parser_p

---
 rtl/itch_pkg.sv | 71 +++++++
 rtl/itch_byte_gather.sv | 34 +++
 rtl/itch_exec_price_parser_p.sv | 137 +++++++++++++
 tb/tb_itch_exec_price_parser_p.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/itch_pkg.sv
// rtl/itch_pkg.sv - ITCH executed-with-price message layout, parser states and field decode
package itch_pkg;

    localparam int EXEC_PRICE_LEN = 51;
    localparam int CNT_W          = 6;

    localparam int TIMESTAMP_OFF         = 0;
    localparam int TIMESTAMP_LEN         = 4;
    localparam int ORDER_ID_OFF          = 4;
    localparam int ORDER_ID_LEN          = 8;
    localparam int ORDER_BOOK_ID_OFF     = 12;
    localparam int ORDER_BOOK_ID_LEN     = 4;
    localparam int SIDE_OFF              = 16;
    localparam int SIDE_LEN              = 1;
    localparam int EXECUTED_QTY_OFF      = 17;
    localparam int EXECUTED_QTY_LEN      = 8;
    localparam int MATCH_ID_OFF          = 25;
    localparam int MATCH_ID_LEN          = 8;
    localparam int COMBO_GROUP_ID_OFF    = 33;
    localparam int COMBO_GROUP_ID_LEN    = 4;
    localparam int RESERVED1_OFF         = 37;
    localparam int RESERVED1_LEN         = 4;
    localparam int RESERVED2_OFF         = 41;
    localparam int RESERVED2_LEN         = 4;
    localparam int TRADE_PRICE_OFF       = 45;
    localparam int TRADE_PRICE_LEN       = 4;
    localparam int OCCURRED_AT_CROSS_OFF = 49;
    localparam int OCCURRED_AT_CROSS_LEN = 1;
    localparam int PRINTABLE_OFF         = 50;
    localparam int PRINTABLE_LEN         = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_HOLD
    } parse_state_e;

    typedef struct packed {
        logic [31:0] timestamp;
        logic [63:0] order_id;
        logic [31:0] order_book_id;
        logic [7:0]  side;
        logic [63:0] executed_qty;
        logic [63:0] match_id;
        logic [31:0] combo_group_id;
        logic [31:0] reserved1;
        logic [31:0] reserved2;
        logic [31:0] trade_price;
        logic [7:0]  occurred_at_cross;
        logic [7:0]  printable;
    } exec_price_t;

    // Buffer byte j sits at bits [8j+7:8j], so a plain slice is already little-endian.
    function automatic exec_price_t decode_exec_price(input logic [EXEC_PRICE_LEN*8-1:0] msg);
        exec_price_t f;
        f.timestamp         = msg[TIMESTAMP_OFF*8         +: TIMESTAMP_LEN*8];
        f.order_id          = msg[ORDER_ID_OFF*8          +: ORDER_ID_LEN*8];
        f.order_book_id     = msg[ORDER_BOOK_ID_OFF*8     +: ORDER_BOOK_ID_LEN*8];
        f.side              = msg[SIDE_OFF*8              +: SIDE_LEN*8];
        f.executed_qty      = msg[EXECUTED_QTY_OFF*8      +: EXECUTED_QTY_LEN*8];
        f.match_id          = msg[MATCH_ID_OFF*8          +: MATCH_ID_LEN*8];
        f.combo_group_id    = msg[COMBO_GROUP_ID_OFF*8    +: COMBO_GROUP_ID_LEN*8];
        f.reserved1         = msg[RESERVED1_OFF*8         +: RESERVED1_LEN*8];
        f.reserved2         = msg[RESERVED2_OFF*8         +: RESERVED2_LEN*8];
        f.trade_price       = msg[TRADE_PRICE_OFF*8       +: TRADE_PRICE_LEN*8];
        f.occurred_at_cross = msg[OCCURRED_AT_CROSS_OFF*8 +: OCCURRED_AT_CROSS_LEN*8];
        f.printable         = msg[PRINTABLE_OFF*8         +: PRINTABLE_LEN*8];
        return f;
    endfunction

endpackage

// File: rtl/itch_byte_gather.sv
// rtl/itch_byte_gather.sv - copies taken_i beat bytes from pos_i into the message buffer at count_i
module itch_byte_gather
    import itch_pkg::*;
#(
    parameter  int BEAT_BYTES = 8,
    localparam int OFF_W      = $clog2(BEAT_BYTES)
) (
    input  logic [EXEC_PRICE_LEN*8-1:0] buf_i,
    input  logic [8*BEAT_BYTES-1:0]     beat_i,
    input  logic [OFF_W-1:0]            pos_i,
    input  logic [CNT_W-1:0]            count_i,
    input  logic [CNT_W-1:0]            taken_i,
    output logic [EXEC_PRICE_LEN*8-1:0] buf_o
);

    logic [7:0]       beat_bytes [BEAT_BYTES];
    logic [OFF_W-1:0] src_idx    [EXEC_PRICE_LEN];

    for (genvar b = 0; b < BEAT_BYTES; b++) begin : g_unpack
        assign beat_bytes[b] = beat_i[b*8 +: 8];
    end

    // Each message byte in [count, count+taken) pulls from beat byte pos + (j - count).
    always_comb begin
        buf_o = buf_i;
        for (int j = 0; j < EXEC_PRICE_LEN; j++) begin
            src_idx[j] = OFF_W'(j - int'(count_i) + int'(pos_i));
            if (j >= int'(count_i) && j < int'(count_i) + int'(taken_i)) begin
                buf_o[j*8 +: 8] = beat_bytes[src_idx[j]];
            end
        end
    end

endmodule

// File: rtl/itch_exec_price_parser_p.sv
// rtl/itch_exec_price_parser_p.sv - gathers a 51-byte executed-with-price message from beats and decodes it
module itch_exec_price_parser_p
    import itch_pkg::*;
#(
    parameter  int BEAT_BYTES = 8,
    localparam int OFF_W      = $clog2(BEAT_BYTES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*BEAT_BYTES-1:0] in_data,
    input  logic                    in_last,
    input  logic                    start,
    input  logic [OFF_W-1:0]        start_offset,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             timestamp,
    output logic [63:0]             order_id,
    output logic [31:0]             order_book_id,
    output logic [7:0]              side,
    output logic [63:0]             executed_qty,
    output logic [63:0]             match_id,
    output logic [31:0]             combo_group_id,
    output logic [31:0]             reserved1,
    output logic [31:0]             reserved2,
    output logic [31:0]             trade_price,
    output logic [7:0]              occurred_at_cross,
    output logic [7:0]              printable,
    output logic [OFF_W-1:0]        tracker_out,
    output logic                    err_trunc
);

    parse_state_e                state_q, state_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic [EXEC_PRICE_LEN*8-1:0] buf_q, buf_d;
    logic [OFF_W-1:0]            tracker_q, tracker_d;
    logic                        err_q, err_d;

    logic [OFF_W-1:0]            pos;
    logic [CNT_W-1:0]            count_base;
    logic [CNT_W:0]              avail, remain;
    logic [CNT_W-1:0]            taken, count_sum;
    logic                        accept, take;
    logic [EXEC_PRICE_LEN*8-1:0] gathered;
    exec_price_t                 fields;

    // A start beat begins at start_offset with an empty buffer; continuation beats begin at byte 0.
    assign pos        = (state_q == ST_IDLE)    ? start_offset : '0;
    assign count_base = (state_q == ST_COLLECT) ? count_q      : '0;
    assign avail      = (CNT_W+1)'(BEAT_BYTES)     - (CNT_W+1)'(pos);
    assign remain     = (CNT_W+1)'(EXEC_PRICE_LEN) - (CNT_W+1)'(count_base);
    assign taken      = (avail < remain) ? avail[CNT_W-1:0] : remain[CNT_W-1:0];
    assign count_sum  = count_base + taken;
    assign accept     = in_valid && in_ready;

    itch_byte_gather #(.BEAT_BYTES(BEAT_BYTES)) u_gather (
        .buf_i   (buf_q),
        .beat_i  (in_data),
        .pos_i   (pos),
        .count_i (count_base),
        .taken_i (taken),
        .buf_o   (gathered)
    );

    // Next-state and handshake outputs; completion is checked before in_last so a full message never flags truncation.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        buf_d     = buf_q;
        tracker_d = tracker_q;
        err_d     = 1'b0;
        take      = 1'b0;
        in_ready  = (state_q != ST_HOLD);
        out_valid = (state_q == ST_HOLD);
        unique case (state_q)
            ST_IDLE:    take = accept && start;
            ST_COLLECT: take = accept;
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            end
            default:    state_d = ST_IDLE;
        endcase
        if (take) begin
            buf_d = gathered;
            if (count_sum == CNT_W'(EXEC_PRICE_LEN)) begin
                state_d   = ST_HOLD;
                count_d   = count_sum;
                tracker_d = OFF_W'((CNT_W+1)'(pos) + (CNT_W+1)'(taken));
            end else if (in_last) begin
                state_d = ST_IDLE;
                count_d = '0;
                err_d   = 1'b1;
            end else begin
                state_d = ST_COLLECT;
                count_d = count_sum;
            end
        end
    end

    // State, buffer and status registers; reset wins over any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            buf_q     <= '0;
            tracker_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            buf_q     <= buf_d;
            tracker_q <= tracker_d;
            err_q     <= err_d;
        end
    end

    assign fields            = decode_exec_price(buf_q);
    assign timestamp         = fields.timestamp;
    assign order_id          = fields.order_id;
    assign order_book_id     = fields.order_book_id;
    assign side              = fields.side;
    assign executed_qty      = fields.executed_qty;
    assign match_id          = fields.match_id;
    assign combo_group_id    = fields.combo_group_id;
    assign reserved1         = fields.reserved1;
    assign reserved2         = fields.reserved2;
    assign trade_price       = fields.trade_price;
    assign occurred_at_cross = fields.occurred_at_cross;
    assign printable         = fields.printable;
    assign tracker_out       = tracker_q;
    assign err_trunc         = err_q;

endmodule

// File: tb/tb_itch_exec_price_parser_p.sv
// tb/tb_itch_exec_price_parser_p.sv - self-checking bench for itch_exec_price_parser_p (8- and 16-byte beats)
module tb_itch_exec_price_parser_p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         s;
    logic         in_valid, in_last, start, out_ready;
    logic [127:0] in_data;
    logic [3:0]   start_offset;
    logic         iv8, iv16;

    logic        ir [2];
    logic        ov [2];
    logic        et [2];
    logic [31:0] ts [2];
    logic [63:0] oid [2];
    logic [31:0] obid [2];
    logic [7:0]  sd [2];
    logic [63:0] eq [2];
    logic [63:0] mid [2];
    logic [31:0] cg [2];
    logic [31:0] r1 [2];
    logic [31:0] r2 [2];
    logic [31:0] tp [2];
    logic [7:0]  oc [2];
    logic [7:0]  pr [2];
    logic [2:0]  trk8;
    logic [3:0]  trk16;

    logic         ir_s, ov_s, et_s;
    logic [3:0]   trk_s;
    logic [411:0] obs;

    int checks   = 0;
    int failures = 0;

    assign iv8  = in_valid && !s;
    assign iv16 = in_valid && s;

    itch_exec_price_parser_p #(.BEAT_BYTES(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir[0]), .in_data(in_data[63:0]),
        .in_last(in_last), .start(start), .start_offset(start_offset[2:0]),
        .out_valid(ov[0]), .out_ready(out_ready), .timestamp(ts[0]), .order_id(oid[0]),
        .order_book_id(obid[0]), .side(sd[0]), .executed_qty(eq[0]), .match_id(mid[0]),
        .combo_group_id(cg[0]), .reserved1(r1[0]), .reserved2(r2[0]), .trade_price(tp[0]),
        .occurred_at_cross(oc[0]), .printable(pr[0]), .tracker_out(trk8), .err_trunc(et[0])
    );

    itch_exec_price_parser_p #(.BEAT_BYTES(16)) u16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir[1]), .in_data(in_data),
        .in_last(in_last), .start(start), .start_offset(start_offset),
        .out_valid(ov[1]), .out_ready(out_ready), .timestamp(ts[1]), .order_id(oid[1]),
        .order_book_id(obid[1]), .side(sd[1]), .executed_qty(eq[1]), .match_id(mid[1]),
        .combo_group_id(cg[1]), .reserved1(r1[1]), .reserved2(r2[1]), .trade_price(tp[1]),
        .occurred_at_cross(oc[1]), .printable(pr[1]), .tracker_out(trk16), .err_trunc(et[1])
    );

    always_comb begin
        ir_s  = ir[s];
        ov_s  = ov[s];
        et_s  = et[s];
        trk_s = s ? trk16 : {1'b0, trk8};
        obs   = {ts[s], oid[s], obid[s], sd[s], eq[s], mid[s], cg[s], r1[s], r2[s],
                 tp[s], oc[s], pr[s], trk_s};
    end

    typedef struct {
        int   bb;
        int   off;
        int   last_beat;
        logic exp_err;
        int   hold;
        int   base;
        int   step;
        int   trk;
    } vec_t;

    typedef struct {
        logic         err;
        logic [407:0] msg;
        logic [3:0]   trk;
    } exp_t;

    vec_t vt [10];
    exp_t sbq [$];

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", n, a, e);
        end
    endtask

    function automatic logic [63:0] le(input logic [407:0] m, input int off, input int len);
        logic [63:0] r = '0;
        for (int k = len - 1; k >= 0; k--) r = (r << 8) | 64'(m[(off + k)*8 +: 8]);
        return r;
    endfunction

    function automatic logic [407:0] make_msg(input int base, input int step);
        logic [407:0] m;
        for (int k = 0; k < 51; k++) m[k*8 +: 8] = 8'((base + k*step) & 255);
        return m;
    endfunction

    function automatic logic [127:0] beat_of(input logic [407:0] m, input int j, input int bb, input int off);
        logic [127:0] d = {16{8'h55}};
        int mi;
        for (int i = 0; i < bb; i++) begin
            mi = j*bb + i - off;
            d[i*8 +: 8] = (mi >= 0 && mi < 51) ? m[mi*8 +: 8] : 8'hEE;
        end
        return d;
    endfunction

    task automatic send_beat(input logic [127:0] d, input logic st, input logic lst, input logic [3:0] off);
        @(negedge clk);
        for (int c = 0; c < 20 && !ir_s; c++) @(negedge clk);
        chk("in_ready_before_beat", ir_s, 1);
        in_data = d; start = st; in_last = lst; start_offset = off; in_valid = 1'b1;
        @(posedge clk);
    endtask

    task automatic drive_msg(input vec_t v);
        logic [407:0] m;
        exp_t e;
        int nb;
        m     = make_msg(v.base, v.step);
        e.err = v.exp_err;
        e.msg = m;
        e.trk = 4'(v.trk);
        sbq.push_back(e);
        s  = (v.bb == 16);
        nb = (v.last_beat > 0) ? v.last_beat : (v.off + 51 + v.bb - 1) / v.bb;
        send_beat({16{8'hAA}}, 1'b0, 1'b1, 4'(v.off));
        for (int j = 0; j < nb; j++)
            send_beat(beat_of(m, j, v.bb, v.off), j == 0, (v.last_beat > 0) && (j == nb - 1), 4'(v.off));
        @(negedge clk);
        in_valid = 1'b0; start = 1'b0; in_last = 1'b0;
    endtask

    task automatic check_fields(input logic [407:0] m);
        chk("timestamp",         64'(ts[s]),   le(m, 0, 4));
        chk("order_id",          oid[s],       le(m, 4, 8));
        chk("order_book_id",     64'(obid[s]), le(m, 12, 4));
        chk("side",              64'(sd[s]),   le(m, 16, 1));
        chk("executed_qty",      eq[s],        le(m, 17, 8));
        chk("match_id",          mid[s],       le(m, 25, 8));
        chk("combo_group_id",    64'(cg[s]),   le(m, 33, 4));
        chk("reserved1",         64'(r1[s]),   le(m, 37, 4));
        chk("reserved2",         64'(r2[s]),   le(m, 41, 4));
        chk("trade_price",       64'(tp[s]),   le(m, 45, 4));
        chk("occurred_at_cross", 64'(oc[s]),   le(m, 49, 1));
        chk("printable",         64'(pr[s]),   le(m, 50, 1));
    endtask

    task automatic check_result(input int hold);
        exp_t e;
        logic [411:0] snap;
        for (int c = 0; c < 40 && !ov_s && !et_s; c++) @(negedge clk);
        if (sbq.size() == 0) begin
            checks++; failures++;
            $display("FAIL scoreboard_empty actual=output expected=none");
            return;
        end
        e = sbq.pop_front();
        chk("out_valid", ov_s, !e.err);
        chk("err_trunc", et_s, e.err);
        if (e.err) begin
            @(negedge clk);
            chk("err_pulse_width", et_s, 0);
            chk("no_out_valid_after_trunc", ov_s, 0);
        end else begin
            check_fields(e.msg);
            chk("tracker_out", trk_s, e.trk);
            chk("in_ready_in_hold", ir_s, 0);
            snap = obs;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk("hold_out_valid", ov_s, 1);
                chk("hold_stable", obs === snap, 1);
                chk("hold_in_ready", ir_s, 0);
            end
            out_ready = 1'b1; in_valid = 1'b1; start = 1'b1; in_last = 1'b0;
            in_data = {16{8'h77}}; start_offset = '0;
            @(negedge clk);
            out_ready = 1'b0; in_valid = 1'b0; start = 1'b0;
            chk("idle_after_hold", ov_s, 0);
            chk("in_ready_idle", ir_s, 1);
        end
    endtask

    initial begin
        logic [407:0] m;
        vt[0] = '{8,  0,  0, 1'b0, 0, 8'h00, 1,  3};
        vt[1] = '{8,  5,  0, 1'b0, 0, 8'h00, 1,  0};
        vt[2] = '{16, 12, 0, 1'b0, 0, 8'h00, 1,  15};
        vt[3] = '{8,  0,  4, 1'b1, 0, 8'h10, 3,  0};
        vt[4] = '{8,  7,  0, 1'b0, 0, 8'h80, 37, 2};
        vt[5] = '{16, 0,  0, 1'b0, 1, 8'h21, 11, 3};
        vt[6] = '{16, 3,  2, 1'b1, 0, 8'h05, 7,  0};
        vt[7] = '{8,  3,  0, 1'b0, 3, 8'h40, 13, 6};
        vt[8] = '{8,  2,  1, 1'b1, 0, 8'h09, 5,  0};
        vt[9] = '{8,  0,  7, 1'b0, 0, 8'hC3, 29, 3};

        rst = 1'b1; s = 1'b0; in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
        out_ready = 1'b0; in_data = '0; start_offset = '0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            s = k[0];
            #1;
            chk("rst_out_valid", ov_s, 0);
            chk("rst_err_trunc", et_s, 0);
            chk("rst_outputs_zero", obs == '0, 1);
            chk("rst_in_ready", ir_s, 1);
        end
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            drive_msg(vt[i]);
            check_result(vt[i].hold);
        end

        // Reset arrives together with the third beat of a message.
        s = 1'b0;
        m = make_msg(8'h00, 1);
        send_beat(beat_of(m, 0, 8, 0), 1'b1, 1'b0, 4'd0);
        send_beat(beat_of(m, 1, 8, 0), 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        in_data = beat_of(m, 2, 8, 0); start = 1'b0; in_valid = 1'b1; rst = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rstc_out_valid", ov_s, 0);
        chk("rstc_err_trunc", et_s, 0);
        chk("rstc_outputs_zero", obs == '0, 1);
        chk("rstc_in_ready", ir_s, 1);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rstc_quiet", {ov_s, et_s}, 0);
        end
        drive_msg(vt[0]);
        check_result(0);

        // Reset while a decoded message is being held.
        drive_msg(vt[4]);
        for (int c = 0; c < 40 && !ov_s; c++) @(negedge clk);
        chk("rsth_reached_hold", ov_s, 1);
        if (sbq.size() > 0) void'(sbq.pop_front());
        rst = 1'b1;
        @(negedge clk);
        chk("rsth_out_valid", ov_s, 0);
        chk("rsth_outputs_zero", obs == '0, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("rsth_quiet", {ov_s, et_s}, 0);
        chk("scoreboard_drained", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
